// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU select codes and execute-stage FSM states
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLLV = 4'b1000;
  localparam logic [3:0] ALU_SRLV = 4'b1001;
  localparam logic [3:0] ALU_SRAV = 4'b1010;
  localparam logic [3:0] ALU_MULT = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_seq_multiplier.sv
// rtl/alu_exec_unit_seq_multiplier.sv - unsigned iterative shift-add multiplier
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      count_q;
  logic               busy_q;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step;

  // One shift-add step: upper half accumulates, lower half holds the remaining multiplier bits
  always_comb begin
    sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    step = {sum, prod_q[WIDTH-1:1]};
  end

  // The product after the final step is exposed combinationally so the owner can register it with done
  assign product = step;
  assign busy    = busy_q;
  assign done    = busy_q && (count_q == CW'(1));

  // Iteration registers; start loads operands, then one step per cycle for WIDTH cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      mcand_q <= mcand;
      prod_q  <= {{WIDTH{1'b0}}, mplier};
      count_q <= CW'(WIDTH);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      prod_q  <= step;
      count_q <= count_q - CW'(1);
      if (count_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with iterative signed MULT into HI/LO
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  alu_state_e         state_q, state_d;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [2*WIDTH-1:0] signed_product;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_q;
  logic [WIDTH-1:0]   alu_res;
  logic [SHW-1:0]     var_sh;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (alu_sel == ALU_MULT);
  assign var_sh    = src_a[SHW-1:0];

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) as an unsigned word
  always_comb begin
    mag_a = src_a[WIDTH-1] ? (~src_a + WIDTH'(1)) : src_a;
    mag_b = src_b[WIDTH-1] ? (~src_b + WIDTH'(1)) : src_b;
  end

  seq_multiplier #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .mcand   (mag_a),
    .mplier  (mag_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign signed_product = sign_q ? (~mul_product + (2*WIDTH)'(1)) : mul_product;

  // Single-cycle datapath; undefined codes produce zero
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SLL:  alu_res = src_b << shamt;
      ALU_SRL:  alu_res = src_b >> shamt;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLLV: alu_res = src_b << var_sh;
      ALU_SRLV: alu_res = src_b >> var_sh;
      ALU_SRAV: alu_res = $unsigned($signed(src_b) >>> var_sh);
      default:  alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: MUL lasts until the multiplier's final step, DONE is the completion cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (mul_done)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers; MULT results are written on the final step so they are valid in the DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      sign_q    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (mul_start) begin
        sign_q <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
      end else if (accept) begin
        result    <= alu_res;
        zero      <= (alu_res == '0);
        out_valid <= 1'b1;
      end else if (mul_done && mul_busy) begin
        hi        <= signed_product[2*WIDTH-1:WIDTH];
        lo        <= signed_product[WIDTH-1:0];
        result    <= signed_product[WIDTH-1:0];
        zero      <= (signed_product[WIDTH-1:0] == '0);
        out_valid <= 1'b1;
      end
    end
  end

endmodule
